// File: rtl/genius_pkg.sv
// Shared definitions for the colour-sequence player: FSM encoding, widths,
// default phase lengths and the colour-to-lamp decoder.
package genius_pkg;

  localparam int COLOR_W     = 2;
  localparam int LAMP_W      = 4;
  localparam int TIMER_W     = 8;
  localparam int ON_CYC_DEF  = 8;
  localparam int OFF_CYC_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ON    = 3'd2,
    ST_OFF   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Debug view of the player's internal state.
  typedef struct packed {
    state_t               state;
    logic [COLOR_W-1:0]   color;
  } dbg_t;

  // Colour index to one-hot lamp drive (0->0001 ... 3->1000).
  function automatic logic [LAMP_W-1:0] onehot(input logic [COLOR_W-1:0] c);
    logic [LAMP_W-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// 8-bit loadable down-counter. tc_o is high while the count is zero, so a
// load of V produces a phase that lasts V+1 cycles.
module seq_timer
  import genius_pkg::*;
(
  input  logic               clk_i,
  input  logic               r_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] value_i,
  output logic               tc_o
);

  logic [TIMER_W-1:0] count;

  // Load has priority over counting; the counter parks at zero.
  always_ff @(posedge clk_i) begin
    if (r_i) begin
      count <= '0;
    end else if (load_i) begin
      count <= value_i;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc_o = (count == '0);

endmodule

// File: rtl/seq_player.sv
// Plays round_i+1 colours from an external combinational sequence memory.
// Each colour takes one FETCH cycle, ON_CYC lit cycles and OFF_CYC dark
// cycles; a one-cycle done_o pulse follows the last dark period.
// Handshake: start_i is a level sampled only in IDLE; busy_o is high from the
// cycle after acceptance until the player is back in IDLE, so a new start is
// accepted only when busy_o is low. abort_i cancels any non-IDLE state.
module seq_player
  import genius_pkg::*;
#(
  parameter int N       = 4,
  parameter int ON_CYC  = ON_CYC_DEF,
  parameter int OFF_CYC = OFF_CYC_DEF
) (
  input  logic               clk_i,
  input  logic               r_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [N-1:0]       round_i,
  output logic [N-1:0]       addr_o,
  input  logic [COLOR_W-1:0] data_i,
  output logic [LAMP_W-1:0]  led_o,
  output logic               busy_o,
  output logic               done_o,
  output dbg_t               dbg_o
);

  localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYC - 1);
  localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYC - 1);

  state_t               state;
  logic [N-1:0]         idx;
  logic [N-1:0]         len;
  logic [COLOR_W-1:0]   color;
  logic                 tmr_load;
  logic [TIMER_W-1:0]   tmr_value;
  logic                 tmr_tc;

  seq_timer u_timer (
    .clk_i   (clk_i),
    .r_i     (r_i),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .tc_o    (tmr_tc)
  );

  // Reload the timer on the edge that enters ON (leaving FETCH) or OFF.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = ON_LOAD;
    if (state == ST_FETCH) begin
      tmr_load  = 1'b1;
      tmr_value = ON_LOAD;
    end else if (state == ST_ON && tmr_tc) begin
      tmr_load  = 1'b1;
      tmr_value = OFF_LOAD;
    end
  end

  // Playback FSM with registered lamp, busy and done outputs.
  always_ff @(posedge clk_i) begin
    if (r_i) begin
      state  <= ST_IDLE;
      idx    <= '0;
      len    <= '0;
      color  <= '0;
      led_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else if (abort_i && state != ST_IDLE) begin
      state  <= ST_IDLE;
      idx    <= '0;
      led_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            len    <= round_i;
            idx    <= '0;
            busy_o <= 1'b1;
            state  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          color <= data_i;
          led_o <= onehot(data_i);
          state <= ST_ON;
        end
        ST_ON: begin
          if (tmr_tc) begin
            led_o <= '0;
            state <= ST_OFF;
          end
        end
        ST_OFF: begin
          if (tmr_tc) begin
            if (idx == len) begin
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          idx    <= '0;
          state  <= ST_IDLE;
        end
        default: begin
          led_o  <= '0;
          busy_o <= 1'b0;
          done_o <= 1'b0;
          idx    <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr_o      = idx;
  assign dbg_o.state = state;
  assign dbg_o.color = color;

endmodule

// File: tb/tb_seq_player.sv
// Scoreboard bench for seq_player: drivers push expected flash/done events,
// a monitor extracts events from the DUT outputs and compares them in order.
module tb_seq_player;
  import genius_pkg::*;

  localparam int N   = 4;
  localparam int PER = 1 + 8 + 4;
  localparam int W   = 40;
  localparam logic [3:0] K_FLASH = 4'd1;
  localparam logic [3:0] K_DONE  = 4'd2;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] round = '0;
  logic [N-1:0] addr;
  logic [1:0]   data;
  logic [3:0]   led;
  logic         busy;
  logic         done;
  dbg_t         dbg;

  logic [1:0]   mem [16];
  logic [W-1:0] exp_q[$];
  int           cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic         mon_en = 1'b0;

  assign data = mem[addr];

  seq_player #(.N(N), .ON_CYC(8), .OFF_CYC(4)) dut (
    .clk_i   (clk),
    .r_i     (r),
    .start_i (start),
    .abort_i (abort),
    .round_i (round),
    .addr_o  (addr),
    .data_i  (data),
    .led_o   (led),
    .busy_o  (busy),
    .done_o  (done),
    .dbg_o   (dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ev(input logic [3:0] kind, input int st,
                                      input int ln, input logic [3:0] l,
                                      input int a);
    return {kind, 16'(st), 8'(ln), l, 4'(a), 4'h0};
  endfunction

  function automatic logic [3:0] lamp(input logic [1:0] c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected events for a full playback whose start is sampled in cycle t0.
  task automatic push_play(input int t0, input int len);
    for (int k = 0; k <= len; k++)
      exp_q.push_back(ev(K_FLASH, t0 + 2 + PER * k, 8, lamp(mem[k]), k));
    exp_q.push_back(ev(K_DONE, t0 + 1 + (len + 1) * PER, 0, 4'h0, 0));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d events still pending, expected 0 (cycle %0d)", exp_q.size(), cyc);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: turns lamp activity and done pulses into events, compares in order.
  initial begin : monitor
    logic [3:0] prev_led;
    logic [3:0] f_led;
    int         f_start;
    int         f_addr;
    logic [W-1:0] got;
    logic [W-1:0] want;
    prev_led = 4'h0;
    f_led = 4'h0;
    f_start = 0;
    f_addr = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        got = '0;
        if (led != 4'h0 && prev_led == 4'h0) begin
          f_start = cyc;
          f_led   = led;
          f_addr  = int'(addr);
        end else if (led != 4'h0 && led != prev_led) begin
          check("led_stable", int'(led), int'(prev_led));
        end
        if (led == 4'h0 && prev_led != 4'h0)
          got = ev(K_FLASH, f_start, cyc - f_start, f_led, f_addr);
        if (done === 1'b1)
          got = ev(K_DONE, cyc, 0, 4'h0, 0);
        if (got != '0) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL event: got %h expected none (cycle %0d)", got, cyc);
          end else begin
            want = exp_q.pop_front();
            if (got != want) begin
              fails++;
              $display("FAIL event: got %h expected %h (cycle %0d)", got, want, cyc);
            end
          end
        end
        prev_led = led;
      end
    end
  end

  initial begin : driver
    int t0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    mem[0] = 2'd1; mem[1] = 2'd3; mem[2] = 2'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_led", int'(led), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_addr", int'(addr), 0);
    check("reset_state", int'(dbg.state), int'(ST_IDLE));
    r = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Three colours {1,3,0}: done at cycle 40.
    round = 4'd2; start = 1'b1; t0 = cyc;
    push_play(t0, 2);
    @(negedge clk);
    start = 1'b0;
    check("t1_busy", int'(busy), 1);
    check("t1_fetch_led", int'(led), 0);
    drain(80);
    check("t1_idle_busy", int'(busy), 0);

    // Single colour with abort raised in IDLE alongside start: abort ignored.
    mem[0] = 2'd2;
    round = 4'd0; start = 1'b1; abort = 1'b1; t0 = cyc;
    push_play(t0, 0);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    drain(40);

    // start held high through a round_i=1 playback; round_i changed mid-way.
    mem[0] = 2'd1;
    round = 4'd1; start = 1'b1; t0 = cyc;
    push_play(t0, 1);
    push_play(t0 + 2 * PER + 2, 1);
    wait_until(t0 + 5);
    round = 4'd3;
    wait_until(t0 + 20);
    round = 4'd1;
    wait_until(t0 + 2 * PER + 2);
    check("hold_idle_busy", int'(busy), 0);
    @(negedge clk);
    check("hold_restart_busy", int'(busy), 1);
    start = 1'b0;
    drain(60);

    // Abort during the second ON period.
    round = 4'd2; start = 1'b1; t0 = cyc;
    exp_q.push_back(ev(K_FLASH, t0 + 2, 8, lamp(mem[0]), 0));
    exp_q.push_back(ev(K_FLASH, t0 + 2 + PER, 4, lamp(mem[1]), 1));
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 2 + PER + 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_led", int'(led), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_addr", int'(addr), 0);
    check("abort_state", int'(dbg.state), int'(ST_IDLE));
    drain(10);
    repeat (5) @(negedge clk);

    // Reset during the first OFF, then replay from index 0.
    round = 4'd2; start = 1'b1; t0 = cyc;
    exp_q.push_back(ev(K_FLASH, t0 + 2, 8, lamp(mem[0]), 0));
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 11);
    r = 1'b1;
    @(negedge clk);
    r = 1'b0;
    check("rst_led", int'(led), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(addr), 0);
    drain(10);
    start = 1'b1; t0 = cyc;
    push_play(t0, 2);
    @(negedge clk);
    start = 1'b0;
    drain(80);

    // Longest round: 16 colours, addresses 0..15, done at cycle 209.
    for (int i = 0; i < 16; i++) mem[i] = 2'($urandom_range(0, 3));
    round = 4'd15; start = 1'b1; t0 = cyc;
    push_play(t0, 15);
    @(negedge clk);
    start = 1'b0;
    drain(260);
    check("final_busy", int'(busy), 0);
    check("final_addr", int'(addr), 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 The block SHALL have parameter N, default 4, width of round length and sequence index.
REQ-002 The block SHALL have parameter ON_CYC, default 8, clock cycles each color is lit (legal 1..255).
REQ-003 The block SHALL have parameter OFF_CYC, default 4, dark clock cycles after each color (legal 1..255).
REQ-004 The block SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port r_i  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port start_i  input  1  begin playback; sampled only in IDLE.
REQ-007 The block SHALL have port abort_i  input  1  cancel playback; return to IDLE.
REQ-008 The block SHALL have port round_i  input  N  last index to play; round_i+1 colors are played.
REQ-009 The block SHALL have port addr_o  output  N  sequence-memory address (current index).
REQ-010 The block SHALL have port data_i  input  2  color at addr_o from combinational-read sequence memory.
REQ-011 The block SHALL have port led_o  output  4  one-hot lamp drive: color 0->0001, 1->0010, 2->0100, 3->1000.
REQ-012 The block SHALL have port busy_o  output  1  high in every state except IDLE.
REQ-013 The block SHALL have port done_o  output  1  one-cycle pulse after the final OFF period completes.

Function
REQ-014 The block SHALL implement states IDLE, FETCH, ON, OFF and DONE.
REQ-015 In IDLE with start_i=1 the block SHALL latch round_i into len, clear idx to 0 and enter FETCH next cycle.
REQ-016 In IDLE with start_i=0 the block SHALL remain in IDLE.
REQ-017 In FETCH, lasting exactly one cycle, the block SHALL drive addr_o=idx, register data_i into color and enter ON.
REQ-018 In ON the block SHALL drive led_o=onehot(color) for exactly ON_CYC cycles, then enter OFF.
REQ-019 In OFF the block SHALL drive led_o=0000 for exactly OFF_CYC cycles.
REQ-020 At the end of OFF, if idx==len, the block SHALL enter DONE; otherwise it SHALL increment idx and enter FETCH.
REQ-021 DONE SHALL last one cycle with done_o=1, then the block SHALL enter IDLE.
REQ-022 led_o SHALL be 0000 in IDLE, FETCH, OFF and DONE.
REQ-023 Each color SHALL occupy exactly 1+ON_CYC+OFF_CYC cycles.
REQ-024 If start_i is sampled in IDLE at cycle 0, done_o SHALL be high at cycle 1+(len+1)*(1+ON_CYC+OFF_CYC).
REQ-025 start_i SHALL be ignored while busy_o=1, and round_i changes after latching SHALL have no effect.
REQ-026 round_i=0 SHALL play exactly one color; round_i=2^N-1 SHALL play 2^N colors with idx never wrapping.
REQ-027 abort_i=1 in any non-IDLE state SHALL force IDLE next cycle with led_o=0000 and no done_o pulse.
REQ-028 abort_i SHALL take priority over the timer terminal count and start_i.
REQ-029 abort_i in IDLE SHALL have no effect.
REQ-030 addr_o SHALL equal idx in all states and SHALL be 0 in IDLE.
REQ-031 data_i SHALL be sampled only in FETCH.

Reset
REQ-032 With r_i=1 at a clock edge, the block SHALL set state=IDLE, idx=0, len=0, color=0, timer=0, led_o=0000, busy_o=0, done_o=0, addr_o=0.
REQ-033 r_i SHALL take priority over abort_i and start_i.
REQ-034 r_i asserted mid-playback SHALL end playback immediately without a done_o pulse.

Structure
REQ-035 Shared package genius_pkg SHALL hold the state encoding, the color width (2), the lamp width (4) and the ON_CYC/OFF_CYC defaults.
REQ-036 Sub-module seq_timer SHALL provide the phase timing: an 8-bit loadable down-counter with load_i, value_i and tc_o, sharing clk_i/r_i.
REQ-037 seq_player SHALL reload seq_timer on entry to ON and on entry to OFF.

Verification
REQ-038 The bench SHALL cover: round_i=2, memory {1,3,0}, start_i one cycle -> led_o=0010,1000,0001 for 8 cycles each, 4 dark cycles between, done_o high at cycle 40 only.
REQ-039 The bench SHALL cover: round_i=0, memory[0]=2 -> one 0100 flash of 8 cycles, done_o at cycle 14.
REQ-040 The bench SHALL cover: start_i held high throughout a round_i=1 playback -> no restart until IDLE, then a new playback begins the cycle after IDLE.
REQ-041 The bench SHALL cover: abort_i during the second ON period -> IDLE next cycle, led_o=0000, busy_o=0, no done_o.
REQ-042 The bench SHALL cover: r_i during OFF -> all outputs 0 next cycle; a subsequent start_i replays from idx 0.
REQ-043 The bench SHALL cover: round_i=15 -> 16 flashes, addr_o 0..15 with no wrap, done_o at cycle 209.
